// File: rtl/uc_control_if.sv
// Handshake bundle between the microc datapath and its control unit.
// Optional UC_STEP_EN adds a single-step qualifier driven by the datapath side.
interface uc_control_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] Opcode;
    logic                zero;
    logic                carry;
`ifdef UC_STEP_EN
    logic                step;
`endif
    logic                we;
    logic                s_inc;
    logic                s_skip;
    logic                s_inm;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                pc_en;
    logic                halted;
    logic                illegal;
    logic [CNT_W-1:0]    retired;

    modport master (
`ifdef UC_STEP_EN
        output step,
`endif
        output Opcode, zero, carry,
        input  we, s_inc, s_skip, s_inm, ALUOp, pc_en, halted, illegal, retired
    );

    modport slave (
`ifdef UC_STEP_EN
        input  step,
`endif
        input  Opcode, zero, carry,
        output we, s_inc, s_skip, s_inm, ALUOp, pc_en, halted, illegal, retired
    );
endinterface

// File: rtl/uc_control.sv
// Control unit for the microc datapath: opcode decode, registered flags, INIT/RUN/HALT FSM
// and a saturating retired-instruction counter. Define UC_STEP_EN for single-step gating.
module uc_control #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned ALUOP_W  = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic         clk,
    input  logic         reset,
    uc_control_if.slave  bus
);
    typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

    state_e              state_q, state_d;
    logic                zero_q, carry_q;
    logic [CNT_W-1:0]    retired_q;
    logic [OPCODE_W-1:0] op;
    logic                exec;
    logic                flag_upd;
    logic                jump_taken;
    logic                we_c, s_inc_c, s_skip_c, s_inm_c, pc_en_c;
    logic [ALUOP_W-1:0]  aluop_c;

    assign op = bus.Opcode;

`ifdef UC_STEP_EN
    assign exec = (state_q == StRun) && bus.step;
`else
    assign exec = (state_q == StRun);
`endif

    always_comb begin
        state_d    = state_q;
        we_c       = 1'b0;
        s_inc_c    = 1'b1;
        s_skip_c   = 1'b0;
        s_inm_c    = 1'b0;
        aluop_c    = '0;
        pc_en_c    = 1'b0;
        flag_upd   = 1'b0;
        jump_taken = 1'b0;
        unique case (state_q)
            StInit: state_d = StRun;
            StRun: begin
                if (exec) begin
                    pc_en_c = 1'b1;
                    unique case (op[5:4])
                        2'b00: begin
                            we_c    = 1'b1;
                            s_inm_c = 1'b1;
                        end
                        2'b01: begin
                            aluop_c  = ALUOP_W'(op[2:0]);
                            we_c     = ~op[3];   // CMP only updates flags
                            flag_upd = 1'b1;
                        end
                        2'b10: begin
                            unique case (op[1:0])
                                2'b00: jump_taken = 1'b1;
                                2'b01: jump_taken = zero_q;
                                2'b10: jump_taken = ~zero_q;
                                2'b11: jump_taken = carry_q;
                                default: jump_taken = 1'b0;
                            endcase
                            s_inc_c = ~jump_taken;
                        end
                        2'b11: begin
                            unique case (op[3:0])
                                4'b0001: begin
                                    pc_en_c = 1'b0;
                                    state_d = StHalt;
                                end
                                4'b0010: s_skip_c = zero_q;
                                4'b0011: s_skip_c = carry_q;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            StHalt: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StInit;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (flag_upd) begin
                zero_q  <= bus.zero;
                carry_q <= bus.carry;
            end
            if (pc_en_c && (retired_q != '1)) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign bus.we      = we_c;
    assign bus.s_inc   = s_inc_c;
    assign bus.s_skip  = s_skip_c;
    assign bus.s_inm   = s_inm_c;
    assign bus.ALUOp   = aluop_c;
    assign bus.pc_en   = pc_en_c;
    assign bus.halted  = (state_q == StHalt);
    assign bus.illegal = (op[5:4] == 2'b11) && (op[3:2] != 2'b00);
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_uc_control.sv
// Self-checking bench for uc_control: directed opcode sequence followed by random
// instructions, all compared against an instruction-level model of the control unit.
module tb_uc_control;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    // Model state: mode 0 = start-up, 1 = running, 2 = halted
    int   m_mode;
    bit   m_z, m_c;
    int   m_ret;

    uc_control_if bus ();

    uc_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for the current opcode, derived from the instruction semantics
    task automatic check_now(input logic [5:0] op, input bit st);
        int cls, lo;
        bit e_we, e_inc, e_skip, e_inm, e_pc, taken;
        int e_alu;
        cls = int'(op) / 16;
        lo  = int'(op) % 16;
        e_we = 0; e_inc = 1; e_skip = 0; e_inm = 0; e_pc = 0; e_alu = 0; taken = 0;
        if (m_mode == 1 && st) begin
            e_pc = 1;
            if (cls == 0) begin
                e_we = 1; e_inm = 1;
            end else if (cls == 1) begin
                e_alu = int'(op) % 8;
                e_we  = (lo < 8);
            end else if (cls == 2) begin
                case (int'(op) % 4)
                    0: taken = 1;
                    1: taken = m_z;
                    2: taken = !m_z;
                    default: taken = m_c;
                endcase
                e_inc = !taken;
            end else begin
                if (lo == 1) e_pc = 0;
                if (lo == 2) e_skip = m_z;
                if (lo == 3) e_skip = m_c;
            end
        end
        chk("we",      32'(bus.we),      32'(e_we));
        chk("s_inc",   32'(bus.s_inc),   32'(e_inc));
        chk("s_skip",  32'(bus.s_skip),  32'(e_skip));
        chk("s_inm",   32'(bus.s_inm),   32'(e_inm));
        chk("ALUOp",   32'(bus.ALUOp),   32'(e_alu));
        chk("pc_en",   32'(bus.pc_en),   32'(e_pc));
        chk("halted",  32'(bus.halted),  32'(m_mode == 2));
        chk("illegal", 32'(bus.illegal), 32'(int'(op) >= 52));
        chk("retired", 32'(bus.retired), 32'(m_ret));
    endtask

    task automatic model_edge(input logic [5:0] op, input bit z, input bit c, input bit st);
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && st) begin
            if (int'(op) / 16 == 1) begin
                m_z = z;
                m_c = c;
            end
            if (op == 6'b110001) m_mode = 2;
            else if (m_ret < 65535) m_ret++;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_z = 0; m_c = 0; m_ret = 0;
    endtask

    task automatic cycle(input logic [5:0] op, input bit z, input bit c, input bit st);
        bit st_eff;
        @(negedge clk);
        bus.Opcode = op;
        bus.zero   = z;
        bus.carry  = c;
`ifdef UC_STEP_EN
        bus.step = st;
        st_eff   = st;
`else
        st_eff = 1'b1;
`endif
        #1;
        check_now(op, st_eff);
        @(posedge clk);
        model_edge(op, z, c, st_eff);
    endtask

    // Asynchronous reset mid-operation, released well before the next rising edge
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        check_now(bus.Opcode, 1'b1);
        #2;
        reset = 1'b1;
        @(posedge clk);
        model_edge(6'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [5:0] op;
        bit         st;
        checks   = 0;
        failures = 0;
        model_reset();
        reset      = 1'b0;
        bus.Opcode = 6'b000101;
        bus.zero   = 1'b0;
        bus.carry  = 1'b0;
`ifdef UC_STEP_EN
        bus.step = 1'b1;
`endif
        #1;
        check_now(bus.Opcode, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_now(bus.Opcode, 1'b1);
        @(posedge clk);
        model_edge(bus.Opcode, 1'b0, 1'b0, 1'b1);

        cycle(6'b000101, 0, 0, 1);  // LI
        cycle(6'b010010, 1, 0, 1);  // ADD, zero=1
        cycle(6'b100001, 0, 1, 1);  // JZ taken
        cycle(6'b100011, 0, 1, 1);  // JC not taken
        cycle(6'b011011, 0, 1, 1);  // CMP, zero=0 carry=1
        cycle(6'b100010, 1, 0, 1);  // JNZ taken
        cycle(6'b100011, 0, 0, 1);  // JC taken
        cycle(6'b010000, 1, 0, 1);  // ALU sets zero
        cycle(6'b110010, 0, 0, 1);  // SKZ skip
        cycle(6'b011001, 0, 0, 1);  // CMP clears zero
        cycle(6'b110010, 0, 0, 1);  // SKZ no skip
        cycle(6'b110011, 0, 0, 1);  // SKC
        cycle(6'b111111, 0, 0, 1);  // illegal
        cycle(6'b110000, 0, 0, 1);  // NOP
`ifdef UC_STEP_EN
        cycle(6'b000001, 0, 0, 0);
        cycle(6'b110001, 0, 0, 0);  // HALT ignored without step
        cycle(6'b000001, 0, 0, 1);
        cycle(6'b000001, 0, 0, 0);
`endif
        cycle(6'b100000, 0, 0, 1);  // J
        cycle(6'b110001, 0, 0, 1);  // HALT
        cycle(6'b000001, 0, 0, 1);
        cycle(6'b010000, 1, 1, 1);
        do_reset();
        cycle(6'b000011, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            if (m_mode == 2 && ($urandom % 4 == 0)) begin
                do_reset();
            end else begin
                op = 6'($urandom % 64);
                if (op == 6'b110001 && ($urandom % 4 != 0)) op = 6'b110000;
                st = ($urandom % 4 != 0);
                cycle(op, 1'($urandom % 2), 1'($urandom % 2), st);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
